vga_sync_driver: RTL

//  Raster-timing source and output stage for the 640x480@60 display path.

---
 rtl/vga_sync_driver_pkg.sv | 26 ++
 rtl/vga_sync_driver_if.sv | 26 ++
 rtl/vga_sync_driver_pixel_tick.sv | 40 ++++
 rtl/vga_sync_driver.sv | 93 +++++++++
 4 files changed

// File: rtl/vga_sync_driver_pkg.sv
// Shared raster-timing definitions for the 640x480@60 display path:
// coordinate/colour widths, default VESA timing and the sync window decode.
package vga_sync_driver_pkg;

  localparam int COLOUR_W = 12;
  localparam int COORD_W  = 10;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_driver_if.sv
// Bundle between the raster source (master) and the pixel generator (slave):
// scan coordinates and timing go out, the combinational pixel colour comes back.
interface vga_sync_driver_if;
  import vga_sync_driver_pkg::*;

  colour_t colour_in;
  logic    ce;
  coord_t  x;
  coord_t  y;
  logic    video_on;
  logic    frame_start;
  logic    hsync;
  logic    vsync;
  colour_t vga_rgb;

  modport master (
    input  colour_in,
    output ce, x, y, video_on, frame_start, hsync, vsync, vga_rgb
  );

  modport slave (
    output colour_in,
    input  ce, x, y, video_on, frame_start, hsync, vsync, vga_rgb
  );

endinterface

// File: rtl/vga_sync_driver_pixel_tick.sv
// Pixel clock-enable divider: ce is high for one clk out of every CLK_DIV,
// coinciding with r_div_cnt == CLK_DIV-1.
module pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  output logic ce
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick: CLK_DIV must be in 1..16");
  end

  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] w_div_next;
  logic             r_ce;

  always_comb begin
    w_div_next = (r_div_cnt == LAST) ? '0 : r_div_cnt + CNT_W'(1);
  end

  // NOTE: ce is a register rather than a decode of r_div_cnt, so it stays low
  // in reset even when CLK_DIV = 1 (where the decode would be constantly true).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt <= '0;
      r_ce      <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_ce      <= (w_div_next == LAST);
    end
  end

  assign ce = r_ce;

endmodule

// File: rtl/vga_sync_driver.sv
// Raster timing source and output stage: scan counters, sync decode and the
// registered, blanked colour path, all advancing on the pixel enable.
module vga_sync_driver
  import vga_sync_driver_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_DISPLAY = DEF_H_DISPLAY,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_DISPLAY = DEF_V_DISPLAY,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  vga_sync_driver_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_driver: H_TOTAL and V_TOTAL must each be <= 1024");
  end

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS        = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS        = coord_t'(V_DISPLAY);
  localparam coord_t H_SYNC_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t H_SYNC_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t V_SYNC_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t V_SYNC_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic    w_ce;
  logic    w_x_wrap;
  logic    w_y_wrap;
  logic    w_video_on;
  coord_t  r_x;
  coord_t  r_y;
  logic    r_hsync;
  logic    r_vsync;
  colour_t r_rgb;

  pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
    .clk    (clk),
    .resetn (resetn),
    .ce     (w_ce)
  );

  assign w_x_wrap   = (r_x == H_LAST);
  assign w_y_wrap   = (r_y == V_LAST);
  assign w_video_on = (r_x < H_VIS) && (r_y < V_VIS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_ce) begin
      r_x <= w_x_wrap ? '0 : r_x + coord_t'(1);
      if (w_x_wrap) begin
        r_y <= w_y_wrap ? '0 : r_y + coord_t'(1);
      end
    end
  end

  // Sync and colour are both taken from the pre-advance x,y on the same edge,
  // so the pins see them with zero relative skew.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rgb   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else if (w_ce) begin
      r_rgb   <= w_video_on ? vga.colour_in : '0;
      r_hsync <= in_window(r_x, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync <= in_window(r_y, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.ce          = w_ce;
  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.video_on    = w_video_on;
  assign vga.frame_start = w_ce & w_x_wrap & w_y_wrap;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.vga_rgb     = r_rgb;

endmodule
